// File: rtl/cam_pkg.sv
// Shared encodings and pixel helpers for the camera frame generator.
package cam_pkg;

  typedef enum logic [1:0] {
    FMT_RGB565     = 2'd0,
    FMT_RGB555     = 2'd1,
    FMT_RAW8       = 2'd2,
    FMT_RGB565_ALT = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_GRADIENT = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_FILL     = 2'd3
  } pat_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bar colours, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // Phase 0 selects the first byte on the wire, phase 1 the second.
  function automatic logic [7:0] pack_byte(input fmt_e f, input logic [23:0] rgb, input logic phase);
    case (f)
      FMT_RGB555: pack_byte = phase ? {rgb[13:11], rgb[7:3]} : {1'b0, rgb[23:19], rgb[15:14]};
      FMT_RAW8:   pack_byte = rgb[15:8];
      default:    pack_byte = phase ? {rgb[12:10], rgb[7:3]} : {rgb[23:19], rgb[15:13]};
    endcase
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Test pattern source: maps a pixel coordinate and pattern select to RGB888.
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] x,
  input  logic [7:0]  y,
  input  pat_e        pat_sel,
  input  logic [7:0]  frame_cnt,
  output logic [23:0] rgb
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [7:0] diag;

  always_comb begin
    diag = x[7:0] + y;
    case (pat_sel)
      PAT_GRADIENT: rgb = {x[7:0], y, diag};
      PAT_CHECKER:  rgb = (x[4] ^ y[4]) ? 24'hFFFFFF : 24'h000000;
      PAT_FILL:     rgb = {3{frame_cnt}};
      default:      rgb = bar_colour(3'(x / 16'(BAR_W)));
    endcase
  end

endmodule

// File: rtl/cam_frame_gen.sv
// Camera-style frame generator (vsync/href/8-bit data) with selectable pattern and format.
// Define CAM_FRAME_GEN_EXT_PIX_EN to add an external pixel source (pix_x/pix_y/pix_rgb/ext_sel).
module cam_frame_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 784,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 510,
  parameter int V_SYNC_LINES = 3,
  parameter int V_START      = 20
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [1:0]  fmt,
  input  logic [1:0]  pat_sel,
`ifdef CAM_FRAME_GEN_EXT_PIX_EN
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  input  logic [23:0] pix_rgb,
  input  logic        ext_sel,
`endif
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic [15:0] frame_cnt,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
  localparam logic [15:0] V_SYNC  = 16'(V_SYNC_LINES);
  localparam logic [15:0] V_FIRST = 16'(V_START);
  localparam logic [15:0] V_END   = 16'(V_START + V_ACTIVE);

  state_e      state, state_nxt;
  logic [15:0] h, v, h_nxt, v_nxt;
  logic        phase, phase_nxt;
  logic        two_byte, step, last_clk, load_cfg;
  fmt_e        fmt_q;
  pat_e        pat_q;
  logic [23:0] pat_rgb, pix_src;
  logic [7:0]  y_lo;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      h          <= '0;
      v          <= '0;
      phase      <= 1'b0;
      fmt_q      <= FMT_RGB565;
      pat_q      <= PAT_BARS;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      h          <= h_nxt;
      v          <= v_nxt;
      phase      <= phase_nxt;
      frame_done <= last_clk;
      if (last_clk)
        frame_cnt <= frame_cnt + 16'd1;
      if (load_cfg) begin
        fmt_q <= fmt_e'(fmt);
        pat_q <= pat_e'(pat_sel);
      end
    end
  end

  // The configuration is reloaded on every edge that starts a frame, so it is stable all frame.
  always_comb begin
    two_byte  = (fmt_q != FMT_RAW8);
    step      = !two_byte || phase;
    last_clk  = (state == ST_RUN) && step && (h == H_LAST) && (v == V_LAST);
    state_nxt = state;
    h_nxt     = h;
    v_nxt     = v;
    phase_nxt = phase;
    load_cfg  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_cfg = 1'b1;
        if (en)
          state_nxt = ST_RUN;
      end
      default: begin
        phase_nxt = two_byte ? ~phase : 1'b0;
        if (step) begin
          if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + 16'd1;
          end else begin
            h_nxt = h + 16'd1;
          end
        end
        if (last_clk) begin
          load_cfg = 1'b1;
          if (!en)
            state_nxt = ST_IDLE;
        end
      end
    endcase
  end

`ifdef CAM_FRAME_GEN_EXT_PIX_EN
  logic ext_q;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)
      ext_q <= 1'b0;
    else if (load_cfg)
      ext_q <= ext_sel;
  end

  assign pix_x   = h;
  assign pix_y   = v - V_FIRST;
  assign pix_src = ext_q ? pix_rgb : pat_rgb;
`else
  assign pix_src = pat_rgb;
`endif

  assign y_lo = 8'(v - V_FIRST);

  cam_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .x         (h),
    .y         (y_lo),
    .pat_sel   (pat_q),
    .frame_cnt (frame_cnt[7:0]),
    .rgb       (pat_rgb)
  );

  assign busy  = (state == ST_RUN);
  assign vsync = busy && (v < V_SYNC);
  assign href  = busy && (h < H_ACT) && (v >= V_FIRST) && (v < V_END);
  assign data  = href ? pack_byte(fmt_q, pix_src, phase) : 8'h00;

endmodule

// File: doc/cam_frame_gen.md
CAM_FRAME_GEN -- requirements
Module: cam_frame_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, active pixels per line (multiple of 8).
REQ-002 SHALL have parameter H_TOTAL, 784, pixel slots per line including blanking.
REQ-003 SHALL have parameter V_ACTIVE, 480, active lines per frame.
REQ-004 SHALL have parameter V_TOTAL, 510, lines per frame.
REQ-005 SHALL have parameter V_SYNC_LINES, 3, lines with vsync high at frame start.
REQ-006 SHALL have parameter V_START, 20, first active line index.
REQ-007 SHALL have port pclk  input  1  pixel clock.
REQ-008 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port en  input  1  run request, sampled at frame boundaries.
REQ-010 SHALL have port fmt  input  2  output format: 0 RGB565, 1 RGB555, 2 RAW8, 3 treated as RGB565.
REQ-011 SHALL have port pat_sel  input  2  pattern: 0 colour bars, 1 gradient, 2 checkerboard, 3 frame fill.
REQ-012 SHALL have ports vsync, href  output  1 each  camera sync strobes.
REQ-013 SHALL have port data  output  8  pixel byte.
REQ-014 SHALL have ports frame_cnt  output  16, frame_done  output  1, busy  output  1.

Function
REQ-015 SHALL implement states IDLE and RUN; IDLE->RUN on any pclk with en=1; RUN->IDLE only on the last clock of a frame when en=0.
REQ-016 SHALL, on IDLE->RUN, start with h=0, v=0, byte phase 0; busy = (state==RUN).
REQ-017 SHALL latch fmt and pat_sel on entry to each frame (h=0, v=0, phase 0); mid-frame changes SHALL be ignored.
REQ-018 SHALL, in 2-byte formats, toggle byte phase every pclk and advance h when phase=1; in RAW8 advance h every pclk.
REQ-019 SHALL wrap h at H_TOTAL-1 to 0 and increment v; wrap v at V_TOTAL-1 to 0.
REQ-020 SHALL drive vsync = RUN && v<V_SYNC_LINES; href = RUN && h<H_ACTIVE && V_START<=v<V_START+V_ACTIVE; both decoded from counter state with zero latency.
REQ-021 SHALL drive data=0 whenever href=0.
REQ-022 SHALL pack RGB888 pixel as RGB565 {R[7:3],G[7:5]} then {G[4:2],B[7:3]}; RGB555 {1'b0,R[7:3],G[7:6]} then {G[5:3],B[7:3]}; RAW8 G[7:0].
REQ-023 SHALL generate pixel (x=h, y=v-V_START): bars = white,yellow,cyan,green,magenta,red,blue,black in 8 equal bars of H_ACTIVE/8; gradient R=x[7:0], G=y[7:0], B=(x+y)[7:0]; checkerboard white when x[4]^y[4] else black; fill R=G=B=frame_cnt[7:0].
REQ-024 SHALL pulse frame_done for exactly one pclk after the last clock of each frame, coincident with frame_cnt incremented by 1 (wraps 0xFFFF->0).

Reset
REQ-025 SHALL, while reset_n=0, force IDLE, h=v=phase=0, frame_cnt=0, and vsync, href, data, frame_done, busy all 0, independent of pclk.
REQ-026 SHALL, on reset mid-frame, discard the partial frame with no frame_done.

Configuration
REQ-027 SHALL, with CAM_FRAME_GEN_EXT_PIX_EN defined, add ports pix_x output 16, pix_y output 16, pix_rgb input 24, ext_sel input 1; ext_sel is latched per REQ-017 and, when 1, pix_rgb (combinational read at current pix_x/pix_y) replaces the pattern.
REQ-028 SHALL, without CAM_FRAME_GEN_EXT_PIX_EN, omit those ports; pattern source only.

Structure
REQ-029 SHALL place fmt/pattern encodings, bar colour table and RGB pack functions in shared package cam_pkg.
REQ-030 SHALL implement pattern generation in sub-module cam_pattern_gen (x, y, pat_sel, frame_cnt -> RGB888).

Verification (H_ACTIVE=8, H_TOTAL=10, V_ACTIVE=2, V_TOTAL=6, V_SYNC_LINES=1, V_START=3)
REQ-031 en=0 for 100 clocks -> vsync=href=busy=frame_done=0, data=0, frame_cnt=0.
REQ-032 en=1, fmt=0, pat_sel=0 -> vsync high clocks 0-19, href high 16 clocks from clock 60; bytes FF,FF, FF,E0 (pixels 0,1), pixel 6 = 00,1F; frame length 120 clocks.
REQ-033 fmt=2, pat_sel=0 -> href 8 clocks per line, data FF,FF,FF,FF,00,00,00,00; frame length 60 clocks.
REQ-034 en dropped mid-frame 2 -> frame 2 completes, frame_done pulse, frame_cnt=2, busy falls next clock, vsync stays 0.
REQ-035 fmt 0->2 during active line -> current frame remains RGB565, next frame RAW8.
REQ-036 reset_n low mid-line -> all outputs 0 immediately; after release with en=1, frame restarts at v=0 with frame_cnt=0.
